// File: rtl/dsp_vector_add_drain_pkg.sv
// Shared types and helpers for the SIMD adder drain stage: lane geometry,
// the unpacked result record and the P-word unpack function.
package dsp_vec_pkg;

    localparam int LANES       = 4;
    localparam int LANE_W      = 8;
    localparam int LANE_STRIDE = 12;
    localparam int P_W         = 48;
    localparam int RES_W       = LANES * LANE_W + LANES;

    typedef struct packed {
        logic [LANES-1:0]             ovf;
        logic [LANES-1:0][LANE_W-1:0] sum;
    } result_t;

    // Each 12-bit lane holds an 8-bit sum with its carry at bit 8; upper bits are junk.
    function automatic result_t unpack_p(input logic [P_W-1:0] p);
        result_t r;
        r = {RES_W{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            r.sum[k] = p[k*LANE_STRIDE +: LANE_W];
            r.ovf[k] = p[k*LANE_STRIDE + LANE_W];
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_vector_add_drain_if.sv
// Operand/result handshake and DSP enable/P bundle of the drain stage.
interface dsp_vector_add_drain_if;
  import dsp_vec_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                dsp_en;
  logic [P_W-1:0]      dsp_p;
  logic                out_valid;
  logic                out_ready;
  logic [LANE_W-1:0]   y_0;
  logic [LANE_W-1:0]   y_1;
  logic [LANE_W-1:0]   y_2;
  logic [LANE_W-1:0]   y_3;
  logic [LANES-1:0]    out_ovf;

  modport master (
    input  in_valid, dsp_p, out_ready,
    output in_ready, dsp_en, out_valid, y_0, y_1, y_2, y_3, out_ovf
  );

  modport slave (
    output in_valid, dsp_p, out_ready,
    input  in_ready, dsp_en, out_valid, y_0, y_1, y_2, y_3, out_ovf
  );

endinterface

// File: rtl/dsp_vector_add_drain_fifo.sv
// Synchronous result FIFO with occupancy output; storage is cleared on reset
// so the head reads as zero whenever the buffer has been reset.
module dsp_vec_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          pop_ok_s;

  assign pop_ok_s = pop & (count_r != {CW{1'b0}});
  assign rdata    = mem_r[rd_ptr_r];
  assign count    = count_r;

  // Storage, pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  dsp_vec_result_fifo_chk #(.DEPTH(DEPTH)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop_ok_s),
    .count (count_r)
  );

endmodule

// File: rtl/dsp_vector_add_drain_fifo_chk.sv
// Simulation checks for the result FIFO: no write into a full buffer, no read of an empty one.
module dsp_vec_result_fifo_chk #(
  parameter int DEPTH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     push,
  input logic                     pop,
  input logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (count == {CW{1'b0}})));

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));

endmodule

// File: rtl/dsp_vector_add_drain.sv
// Drain stage behind the 4-lane DSP adder: drives the shared DSP clock enable
// from FIFO credit, tracks the two DSP register stages and buffers unpacked sums.
module dsp_vector_add_drain
  import dsp_vec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                    clock,
  input logic                    reset,
  dsp_vector_add_drain_if.master io
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          v1_r;
  logic          v2_r;
  logic [CW-1:0] count_s;
  logic [CW-1:0] free_s;
  logic          en_s;
  logic          push_s;
  logic          pop_s;
  result_t       push_data_s;
  result_t       head_s;

  // Credit counts every result already owed a FIFO slot, including those still in the DSP
  always_comb begin
    free_s = CW'(DEPTH) - count_s - CW'(v1_r) - CW'(v2_r);
    if (reset && (free_s != {CW{1'b0}})) begin
      en_s = 1'b1;
    end else begin
      en_s = 1'b0;
    end
  end

  // Valid bits shadowing the DSP input and P registers; they freeze with the enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v1_r <= 1'b0;
      v2_r <= 1'b0;
    end else if (en_s) begin
      v2_r <= v1_r;
      v1_r <= io.in_valid;
    end else begin
      v1_r <= v1_r;
      v2_r <= v2_r;
    end
  end

  assign push_s      = en_s & v2_r;
  assign pop_s       = io.out_ready & (count_s != {CW{1'b0}});
  assign push_data_s = unpack_p(io.dsp_p);

  dsp_vec_result_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (head_s),
    .count (count_s)
  );

  assign io.dsp_en    = en_s;
  assign io.in_ready  = en_s;
  assign io.out_valid = (count_s != {CW{1'b0}});
  assign io.y_0       = head_s.sum[0];
  assign io.y_1       = head_s.sum[1];
  assign io.y_2       = head_s.sum[2];
  assign io.y_3       = head_s.sum[3];
  assign io.out_ovf   = head_s.ovf;

endmodule

// File: tb/tb_dsp_vector_add_drain.sv
// Directed bench for the DSP drain stage: a behavioural 2-stage DSP model feeds
// dsp_p, a scoreboard of reference lane sums checks every popped result.
module tb_dsp_vector_add_drain;
  import dsp_vec_pkg::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a_s   = 32'h0;
  logic [31:0] b_s   = 32'h0;
  logic [31:0] a1_r, b1_r;
  logic [47:0] p_r;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  logic [35:0] q[$];

  dsp_vector_add_drain_if bus();

  dsp_vector_add_drain #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  always #5 clock = ~clock;

  assign bus.dsp_p = p_r;

  // DSP model: input registers then P register, all gated by dsp_en; junk in lane bits 11:9
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      a1_r <= 32'h0;
      b1_r <= 32'h0;
      p_r  <= 48'h0;
    end else if (bus.dsp_en) begin
      a1_r <= a_s;
      b1_r <= b_s;
      for (int k = 0; k < 4; k++)
        p_r[12*k +: 12] <= {3'b101, {1'b0, a1_r[8*k +: 8]} + {1'b0, b1_r[8*k +: 8]}};
    end
  end

  function automatic logic [35:0] ref_sum(input logic [31:0] a, input logic [31:0] b);
    logic [35:0] r;
    logic [8:0]  s;
    r = 36'h0;
    for (int k = 0; k < 4; k++) begin
      s = {1'b0, a[8*k +: 8]} + {1'b0, b[8*k +: 8]};
      r[8*k +: 8] = s[7:0];
      r[32 + k]   = s[8];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: accepted-not-popped items must equal the credit the DUT is holding
  always @(negedge clock) begin
    if (!reset) begin
      q.delete();
    end else begin
      check("credit_en", {63'h0, bus.dsp_en}, {63'h0, (q.size() < DEPTH)});
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_pop", 64'h1, 64'h0);
        end else begin
          check("pop_data", {28'h0, bus.out_ovf, bus.y_3, bus.y_2, bus.y_1, bus.y_0},
                {28'h0, q[0]});
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_sum(a_s, b_s));
        n_acc++;
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  ovf;
  } vec_t;

  task automatic drain(input string name);
    int left;
    left = 200;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && left > 0) begin
      tick();
      left--;
    end
    check(name, {32'h0, q.size()}, 64'h0);
  endtask

  initial begin
    vec_t tbl[5];
    int   base;
    int   lat;
    int   budget;

    tbl[0] = '{a: 32'h04030201, b: 32'h281E140A, y: 32'h2C21160B, ovf: 4'b0000};
    tbl[1] = '{a: 32'h00F00000, b: 32'h00200000, y: 32'h00100000, ovf: 4'b0100};
    tbl[2] = '{a: 32'hFFFFFFFF, b: 32'h01010101, y: 32'h00000000, ovf: 4'b1111};
    tbl[3] = '{a: 32'h80FF7F00, b: 32'h80FF0100, y: 32'h00FE8000, ovf: 4'b1100};
    tbl[4] = '{a: 32'h12345678, b: 32'h11111111, y: 32'h23456789, ovf: 4'b0000};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_dsp_en",    {63'h0, bus.dsp_en},    64'h0);
    check("rst_in_ready",  {63'h0, bus.in_ready},  64'h0);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_y",         {32'h0, bus.y_3, bus.y_2, bus.y_1, bus.y_0}, 64'h0);
    check("rst_ovf",       {60'h0, bus.out_ovf},   64'h0);
    @(posedge clock);
    #3 reset = 1'b1;
    @(negedge clock);
    check("rel_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // Single vectors: latency and unpack
    for (int i = 0; i < 5; i++) begin
      tick();
      a_s = tbl[i].a;
      b_s = tbl[i].b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clock);
      check("vec_in_ready", {63'h0, bus.in_ready}, 64'h1);
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20 && lat == 0; c++) begin
        @(negedge clock);
        if (bus.out_valid) lat = c;
      end
      check("vec_latency", lat, 64'd3);
      check("vec_y",   {32'h0, bus.y_3, bus.y_2, bus.y_1, bus.y_0}, {32'h0, tbl[i].y});
      check("vec_ovf", {60'h0, bus.out_ovf}, {60'h0, tbl[i].ovf});
    end
    tick();

    // Backpressure: credit admits exactly DEPTH operands
    base = n_acc;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (12) begin
      a_s = $urandom;
      b_s = $urandom;
      tick();
    end
    @(negedge clock);
    check("bp_accepts",   n_acc - base, 64'd4);
    check("bp_in_ready",  {63'h0, bus.in_ready},  64'h0);
    check("bp_out_valid", {63'h0, bus.out_valid}, 64'h1);
    tick();
    bus.out_ready = 1'b1;
    repeat (10) begin
      a_s = $urandom;
      b_s = $urandom;
      tick();
    end
    drain("bp_drain");

    // Full-rate streaming with random backpressure
    base   = n_acc;
    budget = 3000;
    bus.in_valid = 1'b1;
    while ((n_acc - base) < 100 && budget > 0) begin
      a_s = $urandom;
      b_s = $urandom;
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      budget--;
    end
    bus.in_valid = 1'b0;
    check("stream_accepts", n_acc - base, 64'd100);
    drain("stream_drain");

    // Asynchronous reset with three operands in flight
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (3) begin
      a_s = $urandom;
      b_s = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid_out_valid_pre", {63'h0, bus.out_valid}, 64'h1);
    #2 reset = 1'b0;
    #1;
    check("mid_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("mid_dsp_en",    {63'h0, bus.dsp_en},    64'h0);
    check("mid_y0",        {56'h0, bus.y_0},       64'h0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    check("mid_count", {59'h0, dut.u_fifo.count}, 64'h0);
    for (int c = 0; c < 6; c++) begin
      check("mid_no_stale", {63'h0, bus.out_valid}, 64'h0);
      @(negedge clock);
    end

    // Coincident push and pop at count 2, wrapping the pointers
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    repeat (2) begin
      a_s = $urandom;
      b_s = $urandom;
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("pp_fill", {59'h0, dut.u_fifo.count}, 64'd2);
    for (int r = 0; r < 3; r++) begin
      a_s = $urandom;
      b_s = $urandom;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      @(negedge clock);
      check("pp_count",     {59'h0, dut.u_fifo.count}, 64'd2);
      check("pp_out_valid", {63'h0, bus.out_valid},    64'h1);
      tick();
    end
    drain("pp_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
